// File: rtl/keccak_sloth_pkg.sv
// keccak_sloth_pkg: register map, ADRS/CHNS codes and sequencer states for the Keccak accelerator sequencers
package keccak_sloth_pkg;
  localparam logic [6:0] KECC_MEMA = 7'd0;
  localparam logic [6:0] KECC_ADRS = 7'd50;
  localparam logic [6:0] KECC_TRIG = 7'd120;
  localparam logic [6:0] KECC_SECN = 7'd122;
  localparam logic [6:0] KECC_CHNS = 7'd123;
  localparam logic [7:0] WOTS_HASH = 8'h00;
  localparam logic [7:0] WOTS_PRF = 8'h05;
  localparam logic [7:0] CHNS_PRF = 8'h40;
  localparam logic [7:0] CHNS_PAD = 8'h80;
  typedef enum logic [3:0] {
    S_IDLE, S_BAD, S_CFG, S_DIG, S_TYPE, S_CADR, S_HADR,
    S_LOAD, S_TRIG, S_WAIT, S_READ, S_RWAIT, S_OUT, S_NEXT
  } wots_state_e;
endpackage

// File: rtl/keccak_bus_port.sv
// keccak_bus_port: single-access accelerator bus issuer with registered read-data capture
module keccak_bus_port (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [3:0]  wen,
  input  logic [6:0]  addr,
  input  logic [31:0] wdata,
  output logic        k_sel,
  output logic [3:0]  k_wen,
  output logic [6:0]  k_addr,
  output logic [31:0] k_wdata,
  input  logic [31:0] k_rdata,
  output logic        rd_valid,
  output logic [31:0] rd_data
);
  logic pend;
  assign k_sel = req;
  assign k_wen = req ? wen : 4'h0;
  assign k_addr = addr;
  assign k_wdata = wdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= 1'b0;
      rd_valid <= 1'b0;
      rd_data <= '0;
    end else begin
      pend <= req && wen == 4'h0;
      rd_valid <= pend;
      if (pend) rd_data <= k_rdata;
    end
  end
endmodule

// File: rtl/keccak_wots_seq.sv
// keccak_wots_seq: runs a batch of WOTS+ chains on the Keccak accelerator through its register port
module keccak_wots_seq
  import keccak_sloth_pkg::*;
#(
  parameter int TMO_CYCLES = 4096,
  parameter int W_MAX = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        op,
  input  logic [7:0]  secn,
  input  logic [6:0]  nchain,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        dig_rd,
  output logic [6:0]  dig_idx,
  input  logic [3:0]  dig_val,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        k_sel,
  output logic [3:0]  k_wen,
  output logic [6:0]  k_addr,
  output logic [31:0] k_wdata,
  input  logic [31:0] k_rdata,
  input  logic        k_irq
);
  localparam int TW = $clog2(TMO_CYCLES + 1);
  wots_state_e state, nxt;
  logic op_r;
  logic [7:0] secn_r;
  logic [6:0] nchain_r, i;
  logic [2:0] k, nw_m1;
  logic [3:0] d, steps;
  logic [TW-1:0] tmo;
  logic req, rd_valid, cfg_ok, last_k, last_i, tmo_hit;
  logic [3:0] wen;
  logic [6:0] addr;
  logic [31:0] wdata;
  assign cfg_ok = (secn == 8'd16 || secn == 8'd24 || secn == 8'd32) && nchain != 7'd0;
  assign steps = op_r ? 4'(W_MAX) - d : d;
  assign last_k = k == nw_m1;
  assign last_i = i + 7'd1 == nchain_r;
  assign tmo_hit = tmo == TW'(TMO_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (start) nxt = cfg_ok ? S_CFG : S_BAD;
      S_BAD:   nxt = S_IDLE;
      S_CFG:   nxt = S_DIG;
      S_DIG:   nxt = S_TYPE;
      S_TYPE:  nxt = S_CADR;
      S_CADR:  nxt = S_HADR;
      S_HADR:  nxt = op_r ? S_LOAD : S_TRIG;
      S_LOAD:  if (in_valid && last_k) nxt = steps == 4'd0 ? S_READ : S_TRIG;
      S_TRIG:  nxt = S_WAIT;
      S_WAIT:  nxt = k_irq ? S_READ : tmo_hit ? S_IDLE : S_WAIT;
      S_READ:  nxt = S_RWAIT;
      S_RWAIT: if (rd_valid) nxt = S_OUT;
      S_OUT:   if (out_ready) nxt = last_k ? S_NEXT : S_READ;
      S_NEXT:  nxt = last_i ? S_IDLE : S_DIG;
      default: nxt = S_IDLE;
    endcase
  end
  always_comb begin
    busy = state != S_IDLE;
    done = state == S_BAD || (state == S_WAIT && !k_irq && tmo_hit) || (state == S_NEXT && last_i);
    dig_rd = state == S_DIG;
    dig_idx = i;
    in_ready = state == S_LOAD;
    out_valid = state == S_OUT;
    req = 1'b0;
    wen = 4'h0;
    addr = KECC_MEMA;
    wdata = '0;
    case (state)
      S_CFG:  begin req = 1'b1; wen = 4'h1; addr = KECC_SECN; wdata = {24'b0, secn_r}; end
      S_TYPE: begin req = 1'b1; wen = 4'h8; addr = KECC_ADRS + 7'd4; wdata = {op_r ? WOTS_HASH : WOTS_PRF, 24'b0}; end
      S_CADR: begin req = 1'b1; wen = 4'h8; addr = KECC_ADRS + 7'd6; wdata = {1'b0, i, 24'b0}; end
      S_HADR: begin req = 1'b1; wen = 4'h8; addr = KECC_ADRS + 7'd7; wdata = {op_r ? {4'b0, d} : 8'h00, 24'b0}; end
      S_LOAD: begin req = in_valid; wen = 4'hf; addr = KECC_MEMA + 7'(k); wdata = in_data; end
      S_TRIG: begin req = 1'b1; wen = 4'h1; addr = KECC_CHNS; wdata = {24'b0, op_r ? {4'b0, steps} : CHNS_PRF | {4'b0, d}}; end
      S_READ: begin req = 1'b1; addr = KECC_MEMA + 7'(k); end
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      op_r <= 1'b0;
      secn_r <= '0;
      nchain_r <= '0;
      nw_m1 <= '0;
      i <= '0;
      k <= '0;
      d <= '0;
      tmo <= '0;
      err <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        op_r <= op;
        secn_r <= secn;
        nchain_r <= nchain;
        nw_m1 <= secn[4:2] - 3'd1;
        i <= '0;
        k <= '0;
        err <= !cfg_ok;
      end
      if (state == S_TYPE) d <= dig_val;
      if ((state == S_LOAD && in_valid) || (state == S_OUT && out_ready)) k <= last_k ? 3'd0 : k + 3'd1;
      if (state == S_TRIG) tmo <= '0;
      if (state == S_WAIT) tmo <= tmo + 1'b1;
      if (state == S_WAIT && !k_irq && tmo_hit) err <= 1'b1;
      if (state == S_NEXT) i <= i + 7'd1;
    end
  end
  keccak_bus_port u_port (
    .clk(clk),
    .rst(rst),
    .req(req),
    .wen(wen),
    .addr(addr),
    .wdata(wdata),
    .k_sel(k_sel),
    .k_wen(k_wen),
    .k_addr(k_addr),
    .k_wdata(k_wdata),
    .k_rdata(k_rdata),
    .rd_valid(rd_valid),
    .rd_data(out_data)
  );
endmodule
